ntt_kernel_core: RTL and testbench



---
 rtl/ntt_kernel_core.sv | 159 +++++++++++++++
 tb/tb_ntt_kernel_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_kernel_core.sv
// ntt_kernel_core: single-stage radix-2 NTT butterfly kernel with on-chip coef and data RAM
module ntt_kernel_core #(
  parameter int pDATA_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clk_2x,
  input  logic                   ld_vld,
  output logic                   ld_rdy,
  input  logic [pDATA_WIDTH-1:0] ld_dat,
  input  logic                   coef_vld,
  output logic                   coef_rdy,
  input  logic [pDATA_WIDTH-1:0] coef_dat,
  output logic                   sw_vld,
  input  logic                   sw_rdy,
  output logic [pDATA_WIDTH-1:0] sw_dat,
  output logic                   sw_lst,
  output logic [4:0]             bpe_act,
  input  logic [7:0]             mode,
  input  logic                   decode
);
  localparam logic [15:0] Q = 16'd12289;
  typedef enum logic [2:0] {IDLE, COEF, LOAD, COMP, STORE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cfg, cfg_nxt;
  logic sw_vld_nxt, sw_lst_nxt;
  logic coef_we, lwe, ren, bfly, adv;
  logic [6:0] la, ra, rb;
  logic tgl, tgl_d, mid, bfly_q;
  logic [6:0] wa_lo, wa_hi;
  logic [127:0] rd_lo, rd_hi, cw, res_lo, res_hi;
  logic [127:0] mem [128];
  logic [127:0] coef_mem [64];
  logic unused_cfg;

  assign unused_cfg = ^{cfg[7:4], cfg[2:0]};
  assign sw_dat = rd_lo;
  assign mid = tgl != tgl_d;
  assign cw = coef_mem[wa_lo[5:0]];

  function automatic logic [31:0] pe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w);
    logic [15:0] a, t, s, d;
    a = x % Q;
    t = 16'((32'(w) * 32'(y)) % 32'(Q));
    s = a + t;
    d = a + Q - t;
    return {d >= Q ? d - Q : d, s >= Q ? s - Q : s};
  endfunction

  for (genvar k = 0; k < 8; k++) begin : g_pe
    assign {res_hi[16*k+:16], res_lo[16*k+:16]} = pe(rd_lo[16*k+:16], rd_hi[16*k+:16], cw[16*k+:16]);
  end

  // next-state, counters, stream handshakes and RAM port control
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    cfg_nxt = cfg;
    sw_vld_nxt = sw_vld;
    sw_lst_nxt = sw_lst;
    coef_rdy = state == COEF;
    ld_rdy = state == LOAD;
    bpe_act = state == COMP ? 5'd8 : 5'd0;
    coef_we = coef_rdy && coef_vld;
    lwe = ld_rdy && ld_vld;
    la = {cnt[0], cnt[6:1]};
    bfly = state == COMP;
    adv = !sw_vld || sw_rdy;
    ren = bfly || (state == STORE && adv && !cnt[7]);
    ra = bfly ? {1'b0, cnt[5:0]} : cnt[6:0];
    rb = {1'b1, cnt[5:0]};
    case (state)
      IDLE: if (decode && mode[1]) begin
        state_nxt = COEF;
        cfg_nxt = mode;
      end
      COEF: if (coef_we) begin
        cnt_nxt = cnt == 8'd63 ? 8'd0 : cnt + 8'd1;
        state_nxt = cnt == 8'd63 ? LOAD : COEF;
      end
      LOAD: if (lwe) begin
        cnt_nxt = cnt == 8'd127 ? 8'd0 : cnt + 8'd1;
        state_nxt = cnt != 8'd127 ? LOAD : cfg[3] ? STORE : COMP;
      end
      COMP: begin
        cnt_nxt = cnt == 8'd63 ? 8'd0 : cnt + 8'd1;
        state_nxt = cnt == 8'd63 ? STORE : COMP;
      end
      STORE: begin
        if (sw_vld && sw_rdy) begin
          sw_vld_nxt = 1'b0;
          sw_lst_nxt = 1'b0;
        end
        if (ren) begin
          cnt_nxt = cnt + 8'd1;
          sw_vld_nxt = 1'b1;
          sw_lst_nxt = cnt == 8'd127;
        end
        if (sw_vld && sw_rdy && sw_lst) begin
          state_nxt = IDLE;
          cnt_nxt = 8'd0;
          cfg_nxt = 8'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control registers; tgl marks clk cycles for the clk_2x phase detector
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      state <= IDLE;
      cnt <= 8'd0;
      cfg <= 8'd0;
      sw_vld <= 1'b0;
      sw_lst <= 1'b0;
      tgl <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      cfg <= cfg_nxt;
      sw_vld <= sw_vld_nxt;
      sw_lst <= sw_lst_nxt;
      tgl <= ~tgl;
    end

  // twiddle storage, beat c holds W[8c..8c+7]
  always_ff @(posedge clk)
    if (coef_we) coef_mem[cnt[5:0]] <= coef_dat;

  // clk-aligned clk_2x edge reads both butterfly beats; mid-cycle edge is the write-back slot
  always_ff @(posedge clk_2x or posedge rstn)
    if (rstn) begin
      tgl_d <= 1'b0;
      bfly_q <= 1'b0;
      rd_lo <= '0;
      rd_hi <= '0;
      wa_lo <= 7'd0;
      wa_hi <= 7'd0;
    end else begin
      tgl_d <= tgl;
      if (!mid) bfly_q <= bfly;
      if (!mid && ren) begin
        rd_lo <= mem[ra];
        rd_hi <= mem[rb];
        wa_lo <= ra;
        wa_hi <= rb;
      end
    end

  // data RAM writes: load beats on the aligned edge, butterfly results mid-cycle
  always_ff @(posedge clk_2x) begin
    if (!mid && lwe) mem[la] <= ld_dat;
    if (mid && bfly_q) begin
      mem[wa_lo] <= res_lo;
      mem[wa_hi] <= res_hi;
    end
  end
endmodule

// File: tb/tb_ntt_kernel_core.sv
// tb_ntt_kernel_core: vector table and scoreboard bench for the NTT butterfly kernel
module tb_ntt_kernel_core;
  localparam int Q = 12289;
  logic clk, clk_2x, rstn, ld_vld, ld_rdy, coef_vld, coef_rdy, sw_vld, sw_rdy, sw_lst, decode;
  logic [127:0] ld_dat, coef_dat, sw_dat;
  logic [4:0] bpe_act;
  logic [7:0] mode;
  int n_run, n_fail;
  logic [15:0] xw [1024];
  logic [15:0] ww [512];
  logic [15:0] got [1024];
  logic [127:0] sb [$];
  typedef struct {
    logic [15:0] x_lo, x_hi, w, e_lo, e_hi;
  } vec_t;
  vec_t vt [8];

  ntt_kernel_core dut (
    .clk(clk), .rstn(rstn), .clk_2x(clk_2x),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dat(ld_dat),
    .coef_vld(coef_vld), .coef_rdy(coef_rdy), .coef_dat(coef_dat),
    .sw_vld(sw_vld), .sw_rdy(sw_rdy), .sw_dat(sw_dat), .sw_lst(sw_lst),
    .bpe_act(bpe_act), .mode(mode), .decode(decode)
  );

  // clk and clk_2x from one process so their rising edges coincide
  initial begin
    clk = 0;
    clk_2x = 0;
    #5;
    forever begin
      clk = 1; clk_2x = 1;
      #5 clk_2x = 0;
      #5 clk = 0; clk_2x = 1;
      #5 clk_2x = 0;
      #5;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] bf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w, input bit hi);
    longint a, t;
    a = longint'(x) % Q;
    t = (longint'(w) * longint'(y)) % Q;
    return hi ? 16'((a - t + Q) % Q) : 16'((a + t) % Q);
  endfunction

  task automatic run(input logic [7:0] md, input int gap, input bit bp, input bit dec_mid, input string tag);
    int to, cyc, busy, s, n, base;
    bit tmo, stable, bp_done, byp;
    logic [127:0] e, hold_d;
    logic hold_l;
    byp = md[3];
    tmo = 0;
    mode = md; decode = 1;
    tick;
    decode = 0; mode = 8'h00;
    chk({tag, "_coef_rdy_on"}, coef_rdy, 1);
    coef_vld = 1;
    for (int c = 0; c < 64; c++) begin
      for (int k = 0; k < 8; k++) coef_dat[16*k+:16] = ww[8*c+k];
      to = 0;
      while (!coef_rdy && to < 50) begin tick; to++; end
      if (to >= 50) tmo = 1;
      tick;
    end
    coef_dat = '1;
    chk({tag, "_coef_rdy_off"}, coef_rdy, 0);
    chk({tag, "_ld_rdy_on"}, ld_rdy, 1);
    for (int b = 0; b < 128; b++) begin
      base = (b % 2) ? 512 + 8 * (b / 2) : 8 * (b / 2);
      for (int k = 0; k < 8; k++) ld_dat[16*k+:16] = xw[base+k];
      ld_vld = 1;
      if (dec_mid && b == 10) begin decode = 1; mode = 8'h0A; end
      to = 0;
      while (!ld_rdy && to < 50) begin tick; to++; end
      if (to >= 50) tmo = 1;
      tick;
      decode = 0; mode = 8'h00;
      coef_vld = 0;
      ld_vld = 0;
      ld_dat = '0;
      if (b != 127) for (int g = 1; g < gap; g++) tick;
    end
    chk({tag, "_hs_timeout"}, tmo, 0);
    for (int si = 0; si < 128; si++) begin
      for (int k = 0; k < 8; k++) begin
        n = 8 * si + k;
        e[16*k+:16] = byp ? xw[n] : n < 512 ? bf(xw[n], xw[n+512], ww[n], 0) : bf(xw[n-512], xw[n], ww[n-512], 1);
      end
      sb.push_back(e);
    end
    sw_rdy = 1;
    cyc = 1; busy = 0;
    while (!sw_vld && cyc < 200) begin
      if (bpe_act == 5'd8) busy++;
      tick;
      cyc++;
    end
    chk({tag, "_store_latency"}, cyc, byp ? 2 : 66);
    chk({tag, "_bpe_cycles"}, busy, byp ? 0 : 64);
    s = 0; to = 0; stable = 1; bp_done = 0;
    while (s < 128 && to < 2000) begin
      if (bp && !bp_done && s == 40) begin
        bp_done = 1;
        sw_rdy = 0;
        hold_d = sw_dat;
        hold_l = sw_lst;
        for (int i = 0; i < 10; i++) begin
          tick;
          to++;
          if (sw_dat !== hold_d || sw_lst !== hold_l || sw_vld !== 1'b1) stable = 0;
        end
        sw_rdy = 1;
      end
      if (sw_vld && sw_rdy) begin
        e = sb.size() > 0 ? sb.pop_front() : '0;
        chk($sformatf("%s_beat%0d", tag, s), sw_dat, e);
        chk($sformatf("%s_lst%0d", tag, s), sw_lst, s == 127);
        for (int k = 0; k < 8; k++) got[8*s+k] = sw_dat[16*k+:16];
        s++;
      end
      tick;
      to++;
    end
    chk({tag, "_beat_count"}, s, 128);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    if (bp) chk({tag, "_bp_stable"}, stable, 1);
    tick;
    chk({tag, "_idle_vld"}, {sw_vld, sw_lst, coef_rdy, ld_rdy}, 4'b0000);
    sw_rdy = 0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rstn = 1; decode = 0; mode = 0; ld_vld = 0; coef_vld = 0;
    ld_dat = '0; coef_dat = '0; sw_rdy = 0;
    vt[0] = '{16'd0, 16'd12288, 16'd12288, 16'd1, 16'd12288};
    vt[1] = '{16'd5, 16'd517, 16'd1, 16'd522, 16'd11777};
    vt[2] = '{16'd65535, 16'd0, 16'd7, 16'd4090, 16'd4090};
    vt[3] = '{16'd12289, 16'd2, 16'd3, 16'd6, 16'd12283};
    vt[4] = '{16'd100, 16'd65535, 16'd65535, 16'd2871, 16'd9618};
    vt[5] = '{16'd12288, 16'd12288, 16'd2, 16'd12286, 16'd1};
    vt[6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vt[7] = '{16'd6000, 16'd1, 16'd6289, 16'd0, 16'd12000};
    repeat (3) tick;
    chk("reset_outputs", {ld_rdy, coef_rdy, sw_vld, sw_lst, bpe_act}, 9'd0);
    chk("reset_sw_dat", sw_dat, 0);
    rstn = 0;
    tick;
    mode = 8'h08; decode = 1;
    tick;
    decode = 0; mode = 8'h00;
    tick;
    chk("no_ntt_bit_ignored", coef_rdy, 0);

    for (int n = 0; n < 1024; n++) xw[n] = 16'(n);
    for (int n = 0; n < 512; n++) ww[n] = 16'(3 * n + 1);
    run(8'h0A, 8, 0, 0, "byp");
    chk("byp_word0", got[0], 0);
    chk("byp_word1023", got[1023], 1023);

    for (int n = 0; n < 1024; n++) xw[n] = 16'(n);
    for (int n = 0; n < 512; n++) ww[n] = 16'd1;
    for (int i = 0; i < 8; i++) begin
      xw[61*i+5] = vt[i].x_lo;
      xw[61*i+5+512] = vt[i].x_hi;
      ww[61*i+5] = vt[i].w;
    end
    run(8'h02, 0, 1, 1, "cmp");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_lo", i), got[61*i+5], vt[i].e_lo);
      chk($sformatf("vec%0d_hi", i), got[61*i+5+512], vt[i].e_hi);
    end
    chk("cmp_word1", got[1], 514);
    chk("cmp_word600", got[600], 11777);

    mode = 8'h02; decode = 1;
    tick;
    decode = 0; mode = 8'h00;
    coef_vld = 1;
    repeat (10) tick;
    #3 rstn = 1;
    #1 chk("async_reset_coef_rdy", coef_rdy, 0);
    tick;
    rstn = 0;
    coef_vld = 0;
    tick;
    chk("post_reset_idle", {coef_rdy, ld_rdy, sw_vld}, 3'b000);

    for (int n = 0; n < 1024; n++) xw[n] = 16'($urandom);
    for (int n = 0; n < 512; n++) ww[n] = 16'($urandom);
    run(8'hF7, 2, 0, 0, "rnd");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
